quadrilatero_mac_sequencer: RTL
===============================

Name: quadrilatero_mac_sequencer

Overview:
Drives one integer MAC unit through a K-step dot-product reduction. The unit's port contract is data, weight, acc and datatype in; acc and finished out.
- Accepts a reduction request carrying K, the datatype and an initial accumulator.
- Accepts K operand pairs over a valid/ready stream.
- Feeds each pair to the MAC and feeds the MAC result back as the next acc input.
- Returns the final accumulator on a response handshake.
Sits between the operand-fetch logic and each MAC instance in the quadrilatero datapath.

Parameters:
MAX_K, 16, maximum reduction length; KW = $clog2(MAX_K+1) is the width of K fields.
CNT_W, 16, width of the optional cycle counter.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_k_i  in  KW  number of MAC steps
req_datatype_i  in  quadrilatero_pkg::datatype_t  SIZE_32/16/8
req_acc_init_i  in  32  initial accumulator
op_valid_i  in  1  operand pair valid
op_ready_o  out  1  operand pair ready
op_data_i  in  32  data word
op_weight_i  in  32  weight word
mac_data_o  out  32  to MAC data_i
mac_weight_o  out  32  to MAC weight_i
mac_acc_o  out  32  to MAC acc_i
mac_datatype_o  out  datatype_t  to MAC op_datatype_i
mac_acc_i  in  32  from MAC acc_o
mac_finished_i  in  1  from MAC mac_finished_o
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_acc_o  out  32  final accumulator
rsp_err_o  out  1  datatype was not SIZE_32/16/8
rsp_cycles_o  out  CNT_W  cycles from request accept to rsp_valid_o (optional feature)

Behaviour:
- Clock and reset: single clock. rst_ni is asynchronous assert, synchronous deassert externally; the state returns to IDLE immediately, including mid-reduction. Any in-flight operand or response is discarded.
- Reset values:
  - all registers 0; mac_datatype_o = SIZE_32; rsp_valid_o = 0; op_ready_o = 0
  - req_ready_o = 1, because it is decoded from IDLE.
- Registers: acc_q, opd_q, opw_q, dt_q, k_q, cnt_q, err_q.
- MAC drive: mac_data_o = opd_q, mac_weight_o = opw_q, mac_acc_o = acc_q, mac_datatype_o = dt_q, all direct from registers.
- FSM states: IDLE, RUN, WAIT, DONE.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i: load acc_q = req_acc_init_i, dt_q, and k_q = min(req_k_i, MAX_K); clear cnt_q.
  - err_q = 1 if the datatype is not one of the three legal encodings.
  - Next state is DONE if k_q would be 0 or err_q is set; otherwise RUN.
- RUN:
  - op_ready_o = 1.
  - On op handshake: latch opd_q and opw_q, go to WAIT.
- WAIT:
  - Hold the MAC inputs until mac_finished_i.
  - On finish: acc_q <= mac_acc_i and cnt_q++.
  - If cnt_q+1 == k_q, go to DONE.
  - Otherwise op_ready_o = 1 in that same cycle. If an op handshake occurs, latch the new pair and stay in WAIT (one step per cycle back-to-back); if not, go to RUN.
  - op_ready_o = 0 in WAIT while mac_finished_i = 0.
- DONE:
  - rsp_valid_o = 1, rsp_acc_o = acc_q, rsp_err_o = err_q.
  - Outputs stay stable until rsp_ready_i; then go to IDLE.
  - req_ready_o = 0 outside IDLE: no request overlap and no same-cycle DONE-to-accept.
- Arithmetic: the accumulation wraps modulo 2^32, as the MAC wraps. The sequencer adds nothing itself.
- Operands offered while not in RUN/WAIT-finish are ignored (ready = 0). Extra operands beyond K stay in the stream for the next request.
- Latency:
  - request accept to first op_ready = 1 cycle
  - with a 1-cycle MAC and a continuous stream, K steps complete in K+1 cycles after the first op handshake, then rsp_valid_o rises.

Optional Feature:
Macro: QUADRILATERO_MAC_SEQ_PERF_EN.
- Defined: a CNT_W counter clears on request accept and increments every cycle while the state is not IDLE/DONE. It saturates at all-ones; rsp_cycles_o = counter, valid with rsp_valid_o.
- Undefined: no counter logic; rsp_cycles_o is tied to 0. The port is always present.

Test Plan:
- Reset mid-reduction: assert rst_ni = 0 in WAIT -> next edge shows req_ready_o = 1, rsp_valid_o = 0, op_ready_o = 0, mac_acc_o = 0.
- SIZE_8 reduction with real MAC, op_valid held high: K=2, acc_init=0, ops (0x01020304, 0x01010101) x2 -> rsp_acc_o = 20, rsp_err_o = 0, rsp_valid_o 3 cycles after first op handshake.
- SIZE_16 signed: K=1, acc_init=5, data=0xFFFF0002, weight=0x00030003 -> rsp_acc_o = 5 + (-3) + 6 = 8.
- K=0 and illegal datatype:
  - K=0, acc_init=0x1234 -> DONE without any op_ready_o, rsp_acc_o = 0x1234.
  - illegal datatype -> rsp_err_o = 1.
- Stall and backpressure: MAC stub holds finished = 0 for 3 cycles per step, and rsp_ready_i is held low 4 cycles -> op_ready_o stays 0 during the stalls, and rsp_acc_o/rsp_valid_o stay stable until rsp_ready_i.
- K overflow and wrap: req_k_i = MAX_K+1 -> exactly MAX_K ops consumed. SIZE_32, acc_init=0xFFFFFFFF, 1*1 -> rsp_acc_o = 0. With PERF_EN, rsp_cycles_o = 2 for K=1 with a 1-cycle MAC.

Source files
------------

// File: rtl/quadrilatero_mac_sequencer.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module  : quadrilatero_mac_sequencer
// Purpose : drives one integer MAC through a K-step dot-product reduction.
//           Optional cycle counter enabled by QUADRILATERO_MAC_SEQ_PERF_EN.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------

package quadrilatero_pkg;
  typedef enum logic [1:0] {
    SIZE_32 = 2'b00,
    SIZE_16 = 2'b01,
    SIZE_8  = 2'b10
  } datatype_t;
endpackage

module quadrilatero_mac_sequencer
  import quadrilatero_pkg::*;
#(
  parameter int MAX_K = 16,
  parameter int CNT_W = 16,
  localparam int KW   = $clog2(MAX_K + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [KW-1:0]              req_k_i,
  input  quadrilatero_pkg::datatype_t req_datatype_i,
  input  logic [31:0]                req_acc_init_i,
  input  logic                       op_valid_i,
  output logic                       op_ready_o,
  input  logic [31:0]                op_data_i,
  input  logic [31:0]                op_weight_i,
  output logic [31:0]                mac_data_o,
  output logic [31:0]                mac_weight_o,
  output logic [31:0]                mac_acc_o,
  output quadrilatero_pkg::datatype_t mac_datatype_o,
  input  logic [31:0]                mac_acc_i,
  input  logic                       mac_finished_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [31:0]                rsp_acc_o,
  output logic                       rsp_err_o,
  output logic [CNT_W-1:0]           rsp_cycles_o
);

  localparam logic [KW-1:0] c_max_k = KW'(MAX_K);
  localparam logic [KW-1:0] c_k_one = KW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_acc;
  logic [31:0]      r_opd;
  logic [31:0]      r_opw;
  datatype_t        r_dt;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    r_cnt;
  logic             r_err;

  logic [KW-1:0]    w_k_clamped;
  logic             w_dt_legal;
  logic             w_last;
  logic             w_req_hs;
  logic             w_op_hs;
  logic             w_step;

  assign w_k_clamped = (req_k_i > c_max_k) ? c_max_k : req_k_i;
  assign w_dt_legal  = req_datatype_i inside {SIZE_32, SIZE_16, SIZE_8};
  assign w_last      = ((r_cnt + c_k_one) == r_k);
  assign w_req_hs    = req_valid_i && req_ready_o;
  assign w_op_hs     = op_valid_i && op_ready_o;
  assign w_step      = (r_state == WAIT) && mac_finished_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    op_ready_o   = 1'b0;
    rsp_valid_o  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_state_next = ((w_k_clamped == '0) || !w_dt_legal) ? DONE : RUN;
        end
      end
      RUN: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        // A finishing step may accept the next pair in the same cycle so
        // a continuous stream sustains one MAC step per cycle.
        if (mac_finished_i) begin
          if (w_last) begin
            w_state_next = DONE;
          end else begin
            op_ready_o = 1'b1;
            if (!op_valid_i) begin
              w_state_next = RUN;
            end
          end
        end
      end
      DONE: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_opd <= '0;
      r_opw <= '0;
      r_dt  <= SIZE_32;
      r_k   <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_acc <= req_acc_init_i;
        r_dt  <= req_datatype_i;
        r_k   <= w_k_clamped;
        r_cnt <= '0;
        r_err <= !w_dt_legal;
      end
      if (w_op_hs) begin
        r_opd <= op_data_i;
        r_opw <= op_weight_i;
      end
      if (w_step) begin
        r_acc <= mac_acc_i;
        r_cnt <= r_cnt + c_k_one;
      end
    end
  end

  assign mac_data_o     = r_opd;
  assign mac_weight_o   = r_opw;
  assign mac_acc_o      = r_acc;
  assign mac_datatype_o = r_dt;
  assign rsp_acc_o      = r_acc;
  assign rsp_err_o      = r_err;

`ifdef QUADRILATERO_MAC_SEQ_PERF_EN
  logic [CNT_W-1:0] r_cycles;

  // Counts only active cycles; saturates rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycles <= '0;
    end else if (w_req_hs) begin
      r_cycles <= '0;
    end else if (((r_state == RUN) || (r_state == WAIT)) && (r_cycles != '1)) begin
      r_cycles <= r_cycles + CNT_W'(1);
    end
  end

  assign rsp_cycles_o = r_cycles;
`else
  assign rsp_cycles_o = '0;
`endif

endmodule

`default_nettype wire
